// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared constants, FSM state type and queue entry type for fetch.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [6:0]  OPC_JAL          = 7'b1101111;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic        fault;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Circular FIFO of fetch entries with synchronous flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  fetch_entry_t                push_entry,
  input  logic                        pop,
  input  logic                        flush,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output fetch_entry_t                head
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  fetch_entry_t         r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   w_rd_ptr_nxt;
  logic [c_ptr_w-1:0]   w_wr_ptr_nxt;

  assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= w_wr_ptr_nxt;
      if (pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= push_entry;
  end

  assign full  = (r_count == c_cnt_w'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : PC generator and fetch queue feeding decode over valid/ready.
//             Define FETCH_BPRED_EN for static backward-taken branch/JAL
//             prediction.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          DEPTH     = 2,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_pred_taken,
  output logic        fetch_fault
);

  localparam int         c_cnt_w     = $clog2(DEPTH) + 1;
  localparam logic [32:0] c_mem_bytes = 33'(MEM_WORDS) << 2;

  fetch_state_e        r_state;
  logic [31:0]         r_pc;
  logic                w_fault;
  logic [31:0]         w_instr;
  logic [31:0]         w_next_pc;
  logic                w_pred_taken;
  logic [31:0]         w_redirect_pc;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [c_cnt_w-1:0]  w_count;
  fetch_entry_t        w_entry;
  fetch_entry_t        w_head;

  assign w_fault       = ({1'b0, r_pc} >= c_mem_bytes);
  assign w_instr       = w_fault ? NOP_INSTR : imem_instr;
  assign w_redirect_pc = redirect_pc & ~32'd3;

`ifdef FETCH_BPRED_EN
  logic [31:0] w_j_imm;
  logic [31:0] w_b_imm;

  assign w_j_imm = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
  assign w_b_imm = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};

  // Backward branches are assumed taken, forward ones not taken.
  always_comb begin
    w_pred_taken = 1'b0;
    w_next_pc    = r_pc + 32'd4;
    if (w_instr[6:0] == OPC_JAL) begin
      w_pred_taken = 1'b1;
      w_next_pc    = r_pc + w_j_imm;
    end else if (w_instr[6:0] == OPC_BRANCH && w_b_imm[31]) begin
      w_pred_taken = 1'b1;
      w_next_pc    = r_pc + w_b_imm;
    end
  end
`else
  assign w_pred_taken = 1'b0;
  assign w_next_pc    = r_pc + 32'd4;
`endif

  // A redirect discards both the capture and the handoff of this cycle.
  assign w_pop  = !w_empty && id_ready && !redirect_valid;
  assign w_push = (r_state == FETCH) && !redirect_valid && (!w_full || id_ready);

  assign w_entry = '{pc: r_pc, instr: w_instr, pred_taken: w_pred_taken, fault: w_fault};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_entry),
    .pop        (w_pop),
    .flush      (redirect_valid),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count),
    .head       (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      r_state <= FETCH;
      r_pc    <= w_redirect_pc;
    end else begin
      case (r_state)
        BOOT: r_state <= FETCH;
        FETCH: begin
          if (w_push) r_pc <= w_next_pc;
          if (w_push && !w_pop && w_count == c_cnt_w'(DEPTH - 1)) r_state <= FULL;
        end
        FULL: begin
          if (w_pop) r_state <= FETCH;
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign imem_pc       = r_pc;
  assign id_valid      = !w_empty;
  assign id_pc         = w_empty ? 32'd0 : w_head.pc;
  assign id_instr      = w_empty ? 32'd0 : w_head.instr;
  assign id_pred_taken = !w_empty && w_head.pred_taken;
  assign fetch_fault   = !w_empty && w_head.fault;

endmodule

`default_nettype wire
